// File: rtl/change_payout_seq.sv
// Greedy change payout: ejects quarters, dimes and nickels until the latched amount is paid, with a drop-sensor jam check.
// The first eject comes 2 cycles after change_valid is accepted. There is no backpressure; requests outside IDLE are dropped.
module change_payout_seq #(
  parameter int TUBE_DEPTH = 15,
  parameter int TIMEOUT    = 8,
  localparam int CW = $clog2(TUBE_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          change_valid,
  input  logic [2:0]    change_amt,
  input  logic          coin_drop,
  input  logic          refill,
  output logic          busy,
  output logic          eject_q,
  output logic          eject_d,
  output logic          eject_n,
  output logic          done,
  output logic          fault,
  output logic          fault_code,
  output logic [2:0]    remaining,
  output logic [CW-1:0] q_cnt,
  output logic [CW-1:0] d_cnt,
  output logic [CW-1:0] n_cnt,
  output logic          exact_only
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL       = CW'(TUBE_DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_WAIT_DROP, S_DONE, S_FAULT
  } state_t;

  typedef enum logic [1:0] {COIN_Q, COIN_D, COIN_N} coin_t;

  state_t        state, state_nxt;
  coin_t         coin, coin_pick;
  logic [2:0]    amt;
  logic [2:0]    coin_val;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic          jam;
  logic          pick_q, pick_d, pick_n;

  // Greedy choice; a tube is only picked when it still holds a coin, so counts never underflow.
  assign pick_q    = (amt >= 3'd5) && (q_cnt != '0);
  assign pick_d    = (amt >= 3'd2) && (d_cnt != '0);
  assign pick_n    = (n_cnt != '0);
  assign coin_pick = pick_q ? COIN_Q : (pick_d ? COIN_D : COIN_N);
  assign timer_inc = timer + TIMER_ONE;

  always_comb begin
    coin_val = 3'd1;
    case (coin)
      COIN_Q:  coin_val = 3'd5;
      COIN_D:  coin_val = 3'd2;
      default: coin_val = 3'd1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      amt   <= '0;
      coin  <= COIN_N;
      timer <= '0;
      jam   <= 1'b0;
      q_cnt <= FULL;
      d_cnt <= FULL;
      n_cnt <= FULL;
    end else begin
      case (state)
        S_IDLE: begin
          if (refill) begin
            q_cnt <= FULL;
            d_cnt <= FULL;
            n_cnt <= FULL;
          end
          if (change_valid) amt <= change_amt;
        end
        S_SELECT: begin
          coin <= coin_pick;
          jam  <= 1'b0;
        end
        // The coin is charged to inventory here even if it later jams.
        S_EJECT: begin
          timer <= '0;
          case (coin)
            COIN_Q:  q_cnt <= q_cnt - CNT_ONE;
            COIN_D:  d_cnt <= d_cnt - CNT_ONE;
            default: n_cnt <= n_cnt - CNT_ONE;
          endcase
        end
        S_WAIT_DROP: begin
          if (coin_drop)                    amt   <= amt - coin_val;
          else if (timer_inc == TIMER_LAST) jam   <= 1'b1;
          else                              timer <= timer_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (change_valid) state_nxt = (change_amt == 3'd0) ? S_DONE : S_SELECT;
      end
      S_SELECT: begin
        if (amt == 3'd0)                     state_nxt = S_DONE;
        else if (pick_q || pick_d || pick_n) state_nxt = S_EJECT;
        else                                 state_nxt = S_FAULT;
      end
      S_EJECT:     state_nxt = S_WAIT_DROP;
      S_WAIT_DROP: begin
        if (coin_drop)                    state_nxt = S_SELECT;
        else if (timer_inc == TIMER_LAST) state_nxt = S_FAULT;
      end
      S_DONE:      state_nxt = S_IDLE;
      S_FAULT:     state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    eject_q    = 1'b0;
    eject_d    = 1'b0;
    eject_n    = 1'b0;
    done       = (state == S_DONE);
    fault      = (state == S_FAULT);
    fault_code = 1'b0;
    remaining  = 3'd0;
    if (state == S_EJECT) begin
      eject_q = (coin == COIN_Q);
      eject_d = (coin == COIN_D);
      eject_n = (coin == COIN_N);
    end
    if (state == S_FAULT) begin
      fault_code = jam;
      remaining  = amt;
    end
  end

  assign exact_only = (n_cnt == '0) || ((d_cnt == '0) && (n_cnt <= CNT_ONE));

endmodule

// File: tb/tb_change_payout_seq.sv
// Directed bench for change_payout_seq: a full-depth instance (a_*) and a single-coin-tube instance (b_*).
module tb_change_payout_seq;

  logic       clock;
  logic       reset;
  logic [1:0] cv, rf, cd;
  logic [2:0] ca;
  bit         sel;

  logic       a_busy, a_eq, a_ed, a_en, a_done, a_fault, a_code, a_x;
  logic [2:0] a_rem;
  logic [3:0] a_q, a_d, a_n;
  logic       b_busy, b_eq, b_ed, b_en, b_done, b_fault, b_code, b_x;
  logic [2:0] b_rem;
  logic [0:0] b_q, b_d, b_n;

  change_payout_seq #(.TUBE_DEPTH(15), .TIMEOUT(8)) dut_a (
    .clock(clock), .reset(reset), .change_valid(cv[0]), .change_amt(ca),
    .coin_drop(cd[0]), .refill(rf[0]), .busy(a_busy), .eject_q(a_eq),
    .eject_d(a_ed), .eject_n(a_en), .done(a_done), .fault(a_fault),
    .fault_code(a_code), .remaining(a_rem), .q_cnt(a_q), .d_cnt(a_d),
    .n_cnt(a_n), .exact_only(a_x));

  change_payout_seq #(.TUBE_DEPTH(1), .TIMEOUT(8)) dut_b (
    .clock(clock), .reset(reset), .change_valid(cv[1]), .change_amt(ca),
    .coin_drop(cd[1]), .refill(rf[1]), .busy(b_busy), .eject_q(b_eq),
    .eject_d(b_ed), .eject_n(b_en), .done(b_done), .fault(b_fault),
    .fault_code(b_code), .remaining(b_rem), .q_cnt(b_q), .d_cnt(b_d),
    .n_cnt(b_n), .exact_only(b_x));

  // Outputs of whichever instance the current row targets.
  logic       m_busy, m_eq, m_ed, m_en, m_done, m_fault, m_code, m_x;
  logic [2:0] m_rem;
  logic [7:0] m_q, m_d, m_n;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_eq    = sel ? b_eq    : a_eq;
  assign m_ed    = sel ? b_ed    : a_ed;
  assign m_en    = sel ? b_en    : a_en;
  assign m_done  = sel ? b_done  : a_done;
  assign m_fault = sel ? b_fault : a_fault;
  assign m_code  = sel ? b_code  : a_code;
  assign m_x     = sel ? b_x     : a_x;
  assign m_rem   = sel ? b_rem   : a_rem;
  assign m_q     = sel ? {7'd0, b_q} : {4'd0, a_q};
  assign m_d     = sel ? {7'd0, b_d} : {4'd0, a_d};
  assign m_n     = sel ? {7'd0, b_n} : {4'd0, a_n};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Eject sequence is encoded 2 bits per coin, oldest first: 1=Q 2=D 3=N.
  typedef struct {
    int sel, amt, dly, nodrop, refw, noise;
    int seq, done, fault, code, rem, lat, ejf, q, d, n, x;
  } vec_t;

  vec_t vt[12];
  int res_seq, res_done, res_fault, res_code, res_rem, res_lat, res_ejf;
  int res_end, res_idle, res_multi;

  task automatic run_payout(input vec_t v);
    int drop_at;
    int ej_cyc;
    int code;
    sel = (v.sel != 0);
    ca  = 3'(v.amt);
    cv[sel] = 1'b1;
    if (v.refw != 0) rf[sel] = 1'b1;
    tick();
    cv = '0; rf = '0;
    res_seq = 0; res_done = 0; res_fault = 0; res_code = -1; res_rem = -1;
    res_lat = -1; res_ejf = -1; res_end = 0; res_idle = 0; res_multi = 0;
    drop_at = -1; ej_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      cd = '0; cv = '0; rf = '0;
      if (m_busy !== 1'b1) res_idle = 1;
      if (int'(m_eq) + int'(m_ed) + int'(m_en) > 1) res_multi = 1;
      if (m_eq || m_ed || m_en) begin
        code    = m_eq ? 1 : (m_ed ? 2 : 3);
        res_seq = (res_seq << 2) | code;
        if (res_lat < 0) res_lat = c;
        ej_cyc  = c;
        drop_at = c + v.dly + 1;
        if (v.noise != 0) cd[sel] = 1'b1;
      end
      if (v.noise != 0) begin
        cv[sel] = 1'b1; rf[sel] = 1'b1; ca = 3'd7;
      end
      if (c == drop_at && v.nodrop == 0) cd[sel] = 1'b1;
      if (m_done || m_fault) begin
        res_done  = int'(m_done);
        res_fault = int'(m_fault);
        res_code  = int'(m_code);
        res_rem   = int'(m_rem);
        if (res_lat < 0) res_lat = c;
        if (ej_cyc >= 0) res_ejf = c - ej_cyc;
        res_end = 1;
        cd = '0; cv = '0; rf = '0;
        break;
      end
      tick();
    end
  endtask

  bit seen;

  initial begin
    reset = 1'b1; cv = '0; rf = '0; cd = '0; ca = '0; sel = 1'b0;
    vt[0]  = '{0,3,0,0,0,0, 'h0B,1,0,0,0,2,-1, 15,14,14,0};
    vt[1]  = '{0,7,1,0,0,0, 'h06,1,0,0,0,2,-1, 14,13,14,0};
    vt[2]  = '{0,6,2,0,0,0, 'h07,1,0,0,0,2,-1, 13,13,13,0};
    vt[3]  = '{0,4,0,0,0,0, 'h0A,1,0,0,0,2,-1, 13,11,13,0};
    vt[4]  = '{0,5,3,0,0,0, 'h01,1,0,0,0,2,-1, 12,11,13,0};
    vt[5]  = '{0,1,6,0,0,0, 'h03,1,0,0,0,2,-1, 12,11,12,0};
    vt[6]  = '{0,0,0,0,0,0, 'h00,1,0,0,0,1,-1, 12,11,12,0};
    vt[7]  = '{0,7,0,0,1,0, 'h06,1,0,0,0,2,-1, 14,14,15,0};
    vt[8]  = '{0,2,0,0,0,1, 'h02,1,0,0,0,2,-1, 14,13,15,0};
    vt[9]  = '{0,1,0,1,0,0, 'h03,0,1,1,1,2, 8, 14,13,14,0};
    vt[10] = '{1,2,0,0,0,0, 'h02,1,0,0,0,2,-1,  1, 0, 1,1};
    vt[11] = '{1,2,0,0,0,0, 'h03,0,1,0,1,2,-1,  1, 0, 0,1};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_busy",   int'(a_busy), 0);
    chk("rst_eject",  int'({a_eq, a_ed, a_en}), 0);
    chk("rst_pulses", int'({a_done, a_fault, a_code}), 0);
    chk("rst_rem",    int'(a_rem), 0);
    chk("rst_cnts",   int'({a_q, a_d, a_n}), 12'hFFF);
    chk("rst_exact",  int'(a_x), 0);
    chk("rst_b_cnts", int'({b_q, b_d, b_n}), 3'b111);

    for (int i = 0; i < 12; i++) begin
      run_payout(vt[i]);
      chk($sformatf("r%0d_end", i),   res_end, 1);
      chk($sformatf("r%0d_seq", i),   res_seq, vt[i].seq);
      chk($sformatf("r%0d_done", i),  res_done, vt[i].done);
      chk($sformatf("r%0d_fault", i), res_fault, vt[i].fault);
      chk($sformatf("r%0d_rem", i),   res_rem, vt[i].rem);
      chk($sformatf("r%0d_lat", i),   res_lat, vt[i].lat);
      chk($sformatf("r%0d_q", i),     int'(m_q), vt[i].q);
      chk($sformatf("r%0d_d", i),     int'(m_d), vt[i].d);
      chk($sformatf("r%0d_n", i),     int'(m_n), vt[i].n);
      chk($sformatf("r%0d_exact", i), int'(m_x), vt[i].x);
      chk($sformatf("r%0d_busy", i),  res_idle, 0);
      chk($sformatf("r%0d_onehot", i), res_multi, 0);
      if (vt[i].fault != 0) chk($sformatf("r%0d_code", i), res_code, vt[i].code);
      if (vt[i].ejf >= 0)   chk($sformatf("r%0d_jam_lat", i), res_ejf, vt[i].ejf);
      tick();
      chk($sformatf("r%0d_idle", i), int'(m_busy), 0);
    end

    // Reset while waiting for a drop: everything returns to reset values, no pulse follows.
    sel = 1'b0;
    ca = 3'd1; cv[0] = 1'b1;
    tick();
    cv = '0;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (a_en) seen = 1'b1;
      else tick();
    end
    chk("mr_eject_seen", int'(seen), 1);
    tick();
    chk("mr_busy_wait", int'(a_busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_busy",  int'(a_busy), 0);
    chk("mr_outs",  int'({a_eq, a_ed, a_en, a_done, a_fault, a_code, a_rem}), 0);
    chk("mr_cnts",  int'({a_q, a_d, a_n}), 12'hFFF);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (a_done || a_fault || a_busy) seen = 1'b1;
      cd[0] = (c == 2);
      tick();
    end
    cd = '0;
    chk("mr_no_pulse", int'(seen), 0);
    chk("mr_cnts_stable", int'({a_q, a_d, a_n}), 12'hFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
